// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART memory loader: FSM state encoding
// and the byte/word geometry used by the packer and the frame parser.
package uart_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_LO,
        ST_ADDR_HI,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM
    } state_e;

endpackage

// File: rtl/uart_mem_loader_if.sv
// Avalon-MM write-only bus between the loader (master) and the on-chip RAM
// s1 port (slave). No waitrequest: every write is accepted.
interface uart_mem_loader_if #(
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [31:0]       writedata;

    modport master (
        output address, byteenable, chipselect, write, writedata
    );

    modport slave (
        input address, byteenable, chipselect, write, writedata
    );
endinterface

// File: rtl/uart_loader_packer.sv
// Little-endian byte-to-word packer: byte n of a word lands in bits
// [8n+7:8n]; word_valid_o fires combinationally with the last byte.
module uart_loader_packer
    import uart_loader_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear_i,
    input  logic                         byte_valid_i,
    input  logic [BYTE_W-1:0]            byte_i,
    output logic                         word_valid_o,
    output logic [WORD_BYTES*BYTE_W-1:0] word_o
);
    localparam int IDX_W  = $clog2(WORD_BYTES);
    localparam int HOLD_W = (WORD_BYTES - 1) * BYTE_W;

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [HOLD_W-1:0] data_q, data_d;

    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        idx_d  = idx_q;
        data_d = data_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (byte_valid_i) begin
            idx_d = idx_q + IDX_W'(1);
            for (int n = 0; n < WORD_BYTES - 1; n++) begin
                if (idx_q == IDX_W'(n)) data_d[n*BYTE_W +: BYTE_W] = byte_i;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of process order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            idx_q  <= idx_d;
            data_q <= data_d;
        end
    end

    assign word_valid_o = byte_valid_i && !clear_i && (idx_q == IDX_W'(WORD_BYTES - 1));
    assign word_o       = {byte_i, data_q};

endmodule

// File: rtl/uart_mem_loader.sv
// Frame parser for UART image download into RAM: SYNC, ADDR(2), LEN(2),
// LEN*4 data bytes, CSUM. Optional inter-byte timeout: LOADER_TIMEOUT_EN.
module uart_mem_loader
    import uart_loader_pkg::*;
#(
    parameter int                ADDR_W         = 11,
    parameter logic [BYTE_W-1:0] SYNC_BYTE      = SYNC_BYTE_DEF
`ifdef LOADER_TIMEOUT_EN
    ,parameter int               TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [BYTE_W-1:0]   rx_data,
    input  logic                rx_valid,
    uart_mem_loader_if.master   bus,
    output logic                busy,
    output logic                done,
    output logic                err
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [15:0]       count_q, count_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        lo_q, lo_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [31:0]       writedata_q, writedata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic        pack_valid, pack_clear, word_valid, timeout;
    logic [31:0] word;

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign tmo_d   = (rx_valid || state_q == ST_IDLE) ? '0 : tmo_q + TMO_W'(1);
    assign timeout = (state_q != ST_IDLE) && !rx_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tmo_q <= '0;
        else          tmo_q <= tmo_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // The packer only holds bytes while in DATA; any exit discards a partial word.
    assign pack_clear = (state_q != ST_DATA) || timeout;

    uart_loader_packer u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (pack_clear),
        .byte_valid_i (pack_valid),
        .byte_i       (rx_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        csum_d      = csum_q;
        lo_d        = lo_q;
        write_d     = 1'b0;
        address_d   = address_q;
        writedata_d = writedata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        pack_valid  = 1'b0;

        if (rx_valid) begin
            unique case (state_q)
                ST_IDLE: if (rx_data == SYNC_BYTE) begin
                    csum_d  = '0;
                    state_d = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    lo_d    = rx_data;
                    state_d = ST_ADDR_HI;
                end
                ST_ADDR_HI: begin
                    ptr_d   = ADDR_W'({rx_data, lo_q});
                    state_d = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    lo_d    = rx_data;
                    state_d = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    count_d = {rx_data, lo_q};
                    state_d = ({rx_data, lo_q} == 16'd0) ? ST_CSUM : ST_DATA;
                end
                ST_DATA: begin
                    pack_valid = 1'b1;
                    csum_d     = csum_q + rx_data;
                    if (word_valid) begin
                        write_d     = 1'b1;
                        address_d   = ptr_q;
                        writedata_d = word;
                        ptr_d       = ptr_q + ADDR_W'(1);
                        count_d     = count_q - 16'd1;
                        if (count_q == 16'd1) state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    done_d  = (rx_data == csum_q);
                    err_d   = (rx_data != csum_q);
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (timeout) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            csum_q      <= '0;
            lo_q        <= '0;
            write_q     <= 1'b0;
            address_q   <= '0;
            writedata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            csum_q      <= csum_d;
            lo_q        <= lo_d;
            write_q     <= write_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.write      = write_q;
    assign bus.chipselect = write_q;
    assign bus.byteenable = {4{write_q}};
    assign bus.address    = address_q;
    assign bus.writedata  = writedata_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: a table of whole frames with expected
// writes/pulses, plus hand sequences for back-to-back bytes, reset and timeout.
module tb_uart_mem_loader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy, done, err;

    uart_mem_loader_if #(.ADDR_W(11)) bus ();

    uart_mem_loader #(
        .ADDR_W    (11),
        .SYNC_BYTE (8'hA5)
`ifdef LOADER_TIMEOUT_EN
        ,.TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Bus monitor: records every write and counts protocol violations.
    int          cyc = 0;
    logic [10:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];
    int          done_cnt = 0, err_cnt = 0, bus_bad = 0;
    logic        prev_write = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.write) begin
            wq_addr.push_back(bus.address);
            wq_data.push_back(bus.writedata);
            wq_cyc.push_back(cyc);
            if (bus.byteenable !== 4'hF || bus.chipselect !== 1'b1) bus_bad++;
            if (prev_write) bus_bad++;
        end else if (bus.byteenable !== 4'h0 || bus.chipselect !== 1'b0) begin
            bus_bad++;
        end
        prev_write = bus.write;
        if (done) done_cnt++;
        if (err)  err_cnt++;
    end

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        done_cnt = 0;
        err_cnt  = 0;
        bus_bad  = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic expect_frame(input string name, input int nw,
                                input logic [10:0] a0, input logic [31:0] d0,
                                input logic [10:0] a1, input logic [31:0] d1,
                                input int exp_done, input int exp_err);
        check({name, " write_count"}, wq_addr.size(), nw);
        if (nw > 0 && wq_addr.size() > 0) begin
            check({name, " addr0"}, 32'(wq_addr[0]), 32'(a0));
            check({name, " data0"}, wq_data[0], d0);
        end
        if (nw > 1 && wq_addr.size() > 1) begin
            check({name, " addr1"}, 32'(wq_addr[1]), 32'(a1));
            check({name, " data1"}, wq_data[1], d1);
        end
        check({name, " done_pulses"}, done_cnt, exp_done);
        check({name, " err_pulses"}, err_cnt, exp_err);
        check({name, " busy_after"}, 32'(busy), 0);
        check({name, " bus_protocol"}, bus_bad, 0);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  b[$];
        int          nw;
        logic [10:0] a0, a1;
        logic [31:0] d0, d1;
        int          exp_done, exp_err;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs[NV];

    initial begin
        vecs[0].name = "one_word";
        vecs[0].b    = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        vecs[0].nw = 1; vecs[0].a0 = 11'h000; vecs[0].d0 = 32'h44332211;
        vecs[0].a1 = '0; vecs[0].d1 = '0; vecs[0].exp_done = 1; vecs[0].exp_err = 0;

        vecs[1].name = "addr_wrap";
        vecs[1].b    = '{8'hA5, 8'hFF, 8'h07, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                         8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
        vecs[1].nw = 2; vecs[1].a0 = 11'h7FF; vecs[1].d0 = 32'h04030201;
        vecs[1].a1 = 11'h000; vecs[1].d1 = 32'h08070605; vecs[1].exp_done = 1; vecs[1].exp_err = 0;

        vecs[2].name = "bad_csum";
        vecs[2].b    = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAB};
        vecs[2].nw = 1; vecs[2].a0 = 11'h000; vecs[2].d0 = 32'h44332211;
        vecs[2].a1 = '0; vecs[2].d1 = '0; vecs[2].exp_done = 0; vecs[2].exp_err = 1;

        vecs[3].name = "garbage_len0";
        vecs[3].b    = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].nw = 0; vecs[3].a0 = '0; vecs[3].d0 = '0;
        vecs[3].a1 = '0; vecs[3].d1 = '0; vecs[3].exp_done = 1; vecs[3].exp_err = 0;

        vecs[4].name = "addr_hi_ignored";
        vecs[4].b    = '{8'hA5, 8'h03, 8'hF8, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
        vecs[4].nw = 1; vecs[4].a0 = 11'h003; vecs[4].d0 = 32'hEFBEADDE;
        vecs[4].a1 = '0; vecs[4].d1 = '0; vecs[4].exp_done = 1; vecs[4].exp_err = 0;
    end

    initial begin
        int c4, c8;
        logic [7:0] b2b[$];

        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset busy",       32'(busy), 0);
        check("reset write",      32'(bus.write), 0);
        check("reset byteenable", 32'(bus.byteenable), 0);
        check("reset done_err",   32'({done, err}), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            clear_mon();
            foreach (vecs[i].b[k]) send_byte(vecs[i].b[k]);
            repeat (3) @(negedge clk);
            expect_frame(vecs[i].name, vecs[i].nw, vecs[i].a0, vecs[i].d0,
                         vecs[i].a1, vecs[i].d1, vecs[i].exp_done, vecs[i].exp_err);
        end

        // Back-to-back bytes: rx_valid held for the whole frame.
        clear_mon();
        b2b = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13,
                8'h14, 8'h15, 8'h16, 8'h17, 8'h9C};
        c4 = 0;
        c8 = 0;
        foreach (b2b[k]) begin
            @(negedge clk);
            rx_data  = b2b[k];
            rx_valid = 1'b1;
            if (k == 8)  c4 = cyc;
            if (k == 12) c8 = cyc;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        expect_frame("back_to_back", 2, 11'h100, 32'h13121110, 11'h101, 32'h17161514, 1, 0);
        if (wq_cyc.size() == 2) begin
            check("b2b write0 timing", wq_cyc[0], c4 + 1);
            check("b2b write1 timing", wq_cyc[1], c8 + 1);
        end else begin
            check("b2b write timing count", wq_cyc.size(), 2);
        end

        // Reset mid-frame after two data bytes, then a clean frame.
        clear_mon();
        foreach (vecs[0].b[k]) if (k < 7) send_byte(vecs[0].b[k]);
        check("midframe busy", 32'(busy), 1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset busy",      32'(busy), 0);
        check("midreset address",   32'(bus.address), 0);
        check("midreset writedata", bus.writedata, 0);
        reset_n = 1'b1;
        @(negedge clk);
        foreach (vecs[0].b[k]) send_byte(vecs[0].b[k]);
        repeat (3) @(negedge clk);
        expect_frame("after_reset", 1, 11'h000, 32'h44332211, '0, '0, 1, 0);

        // Stall mid-frame.
        clear_mon();
        foreach (vecs[0].b[k]) if (k < 6) send_byte(vecs[0].b[k]);
`ifdef LOADER_TIMEOUT_EN
        begin
            int waited = 0;
            while (err_cnt == 0 && waited < 150) begin
                @(negedge clk);
                waited++;
            end
            check("timeout err seen", 32'(err_cnt), 1);
            check("timeout busy",     32'(busy), 0);
            check("timeout no write", wq_addr.size(), 0);
        end
`else
        repeat (200) @(negedge clk);
        check("stall still busy", 32'(busy), 1);
        check("stall no err",     err_cnt, 0);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'hAA);
        repeat (3) @(negedge clk);
        check("stall resume done", done_cnt, 1);
`endif
        clear_mon();
        foreach (vecs[0].b[k]) send_byte(vecs[0].b[k]);
        repeat (3) @(negedge clk);
        expect_frame("after_stall", 1, 11'h000, 32'h44332211, '0, '0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
